axi4l_regbank: RTL

Parametrised AXI4-Lite slave register bank, the generalised successor to the fixed four-register S00_AXI slave in our custom IPs. It exposes NUM_REGS registers of configurable width to a PS/VIP master. Each register has a per-register mode: read/write, read-only (sourced from fabric), or write-one-to-clear (sticky status). It sits between the AXI interconnect and the user logic of an IP, driving a flat control bus and sampling a flat status bus.

---
 rtl/axi4l_regbank.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4l_regbank.sv
`default_nettype none
// ============================================================================
// Module   : axi4l_regbank
// Purpose  : AXI4-Lite slave exposing NUM_REGS registers of DW bits. Each
//            register is read/write, read-only (mirrors hw_in) or
//            write-one-to-clear (sticky bits set by hw_set pulses).
// Ports    : s00_axi_aclk / s00_axi_areset  clock, sync active-high reset
//            s00_axi_aw* / w* / b*           write address, data, response
//            s00_axi_ar* / r*                read address, data
//            reg_out   current value of every register (slice i = reg i)
//            hw_in     RO register sources
//            hw_set    W1C set pulses
//            wr_pulse  one-cycle strobe per register on accepted write
// Revision : 1.0  initial release
// ============================================================================
module axi4l_regbank #(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK           = '0
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_in,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int c_DW       = C_S_AXI_DATA_WIDTH;
    localparam int c_SW       = c_DW / 8;
    localparam int c_ADDR_LSB = $clog2(c_SW);
    localparam int c_IDX_W    = C_S_AXI_ADDR_WIDTH - c_ADDR_LSB;

    localparam logic [c_IDX_W:0] c_NUM_REGS_V  = (c_IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]       c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]       c_RESP_SLVERR = 2'b10;

    localparam logic c_W_IDLE = 1'b0;
    localparam logic c_W_RESP = 1'b1;
    localparam logic c_R_IDLE = 1'b0;
    localparam logic c_R_DATA = 1'b1;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic               r_wstate;
    logic               r_aw_held;
    logic               r_w_held;
    logic [c_IDX_W-1:0] r_aw_idx;
    logic [c_DW-1:0]    r_wdata;
    logic [c_SW-1:0]    r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_wr_fire;
    logic [c_IDX_W-1:0] w_aw_idx;
    logic               w_aw_in_range;
    logic [c_DW-1:0]    w_wdata;
    logic [c_SW-1:0]    w_wstrb;
    logic [c_DW-1:0]    w_strb_mask;
    logic [NUM_REGS-1:0] w_wr_sel;

    // Ready depends only on registered state (and reset), never on valid.
    assign s00_axi_awready = !s00_axi_areset && (r_wstate == c_W_IDLE) && !r_aw_held;
    assign s00_axi_wready  = !s00_axi_areset && (r_wstate == c_W_IDLE) && !r_w_held;

    assign w_aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_w_hs  = s00_axi_wvalid && s00_axi_wready;

    // Use the held copy if already latched, otherwise the live bus value
    // handshaking on this edge.
    assign w_aw_idx = r_aw_held ? r_aw_idx
                                : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_wdata  = r_w_held ? r_wdata : s00_axi_wdata;
    assign w_wstrb  = r_w_held ? r_wstrb : s00_axi_wstrb;

    assign w_wr_fire     = (r_wstate == c_W_IDLE) && (r_aw_held || w_aw_hs)
                           && (r_w_held || w_w_hs);
    assign w_aw_in_range = ({1'b0, w_aw_idx} < c_NUM_REGS_V);

    always_comb begin
        w_strb_mask = '0;
        for (int k = 0; k < c_SW; k++) begin
            w_strb_mask[k*8 +: 8] = {8{w_wstrb[k]}};
        end
    end

    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_sel[i] = w_wr_fire && w_aw_in_range && (w_aw_idx == c_IDX_W'(i));
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_wstate   <= c_W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_sel;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:c_ADDR_LSB];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_wr_fire) begin
                        r_wstate <= c_W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_aw_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
                    end
                end
                c_W_RESP: begin
                    if (s00_axi_bready) begin
                        r_wstate  <= c_W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign s00_axi_bvalid = r_bvalid;
    assign s00_axi_bresp  = r_bresp;
    assign wr_pulse       = r_wr_pulse;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [c_DW-1:0] w_regs [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (RO_MASK[gi]) begin : g_ro
                // No storage: the fabric value is the register.
                assign w_regs[gi] = hw_in[gi*c_DW +: c_DW];
            end else if (W1C_MASK[gi]) begin : g_w1c
                logic [c_DW-1:0] r_val;
                logic [c_DW-1:0] w_clr;
                assign w_clr = w_wr_sel[gi] ? (w_wdata & w_strb_mask) : '0;
                // Set is OR-ed in after the clear so a same-edge set wins.
                always_ff @(posedge s00_axi_aclk) begin
                    if (s00_axi_areset) begin
                        r_val <= '0;
                    end else begin
                        r_val <= (r_val & ~w_clr) | hw_set[gi*c_DW +: c_DW];
                    end
                end
                assign w_regs[gi] = r_val;
            end else begin : g_rw
                logic [c_DW-1:0] r_val;
                always_ff @(posedge s00_axi_aclk) begin
                    if (s00_axi_areset) begin
                        r_val <= '0;
                    end else if (w_wr_sel[gi]) begin
                        r_val <= (r_val & ~w_strb_mask) | (w_wdata & w_strb_mask);
                    end
                end
                assign w_regs[gi] = r_val;
            end
            assign reg_out[gi*c_DW +: c_DW] = w_regs[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic               r_rstate;
    logic               r_rvalid;
    logic [c_DW-1:0]    r_rdata;
    logic [1:0]         r_rresp;

    logic               w_ar_hs;
    logic [c_IDX_W-1:0] w_ar_idx;
    logic               w_ar_in_range;
    logic [c_DW-1:0]    w_rd_val;

    assign s00_axi_arready = !s00_axi_areset && (r_rstate == c_R_IDLE);
    assign w_ar_hs         = s00_axi_arvalid && s00_axi_arready;
    assign w_ar_idx        = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:c_ADDR_LSB];
    assign w_ar_in_range   = ({1'b0, w_ar_idx} < c_NUM_REGS_V);

    // Pre-edge register contents, so a same-edge write is not visible.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == c_IDX_W'(i)) begin
                w_rd_val = w_regs[i];
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rstate <= c_R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate <= c_R_DATA;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_ar_in_range ? w_rd_val : '0;
                        r_rresp  <= w_ar_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
                    end
                end
                c_R_DATA: begin
                    if (s00_axi_rready) begin
                        r_rstate <= c_R_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign s00_axi_rvalid = r_rvalid;
    assign s00_axi_rdata  = r_rdata;
    assign s00_axi_rresp  = r_rresp;

    // Inputs that carry no information for this block.
    logic w_unused;
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[c_ADDR_LSB-1:0], s00_axi_araddr[c_ADDR_LSB-1:0],
                        hw_in, hw_set};

endmodule
`default_nettype wire
